// File: rtl/uart_pkg.sv
// Shared UART definitions: frame parser states, header byte and
// the inter-byte timeout derivation used by the uart blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } rx_state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'h55;

  // About two byte times of line silence (10 bits per byte)
  function automatic int calc_timeout(input int clk_fre,
                                      input int bps);
    return (clk_fre / bps) * 20;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for the frame parser: one synchronous write
// port, one combinational read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Assembles 0x55|LEN|payload|CSUM frames from the uart byte
// receiver, verifies them and streams the payload out.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int         BPS     = 230400,
  parameter int         CLK_FRE = 50_000_000,
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] HDR     = HDR_DEFAULT,
  parameter int         TIMEOUT = calc_timeout(CLK_FRE, BPS)
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] frame_len,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       drop
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GW = $clog2(TIMEOUT + 1);

  rx_state_t   state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] rd_q, rd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        csum_q, csum_d;
  logic        lerr_q, lerr_d;
  logic        tmo_q, tmo_d;
  logic        drop_q, drop_d;
  logic        wr_en;
  logic        hs;
  logic        expired;
  logic        is_last;
  logic [7:0]  rd_byte;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_buf (
    .clk     (sys_clk),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (uart_rx_data),
    .rd_addr (rd_q),
    .rd_data (rd_byte)
  );

  assign is_last = (8'(rd_q) == len_q - 8'd1);
  assign hs      = (state_q == ST_DRAIN) && out_ready;
  // A strobe in the expiry cycle wins over the timeout
  assign expired = !uart_rx_done &&
                   (gap_q == GW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    gap_d   = '0;
    wr_en   = 1'b0;
    csum_d  = 1'b0;
    lerr_d  = 1'b0;
    tmo_d   = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (uart_rx_done && uart_rx_data == HDR) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN, ST_PAYLOAD, ST_CSUM: begin
        gap_d = uart_rx_done ? '0 : gap_q + GW'(1);
        if (expired) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (uart_rx_done) begin
          if (state_q == ST_LEN) begin
            if (uart_rx_data != 8'd0 &&
                uart_rx_data <= 8'(MAX_LEN)) begin
              len_d   = uart_rx_data;
              sum_d   = uart_rx_data;
              idx_d   = '0;
              state_d = ST_PAYLOAD;
            end else begin
              lerr_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (state_q == ST_PAYLOAD) begin
            wr_en = 1'b1;
            sum_d = sum_q + uart_rx_data;
            idx_d = idx_q + IW'(1);
            if (8'(idx_q) == len_q - 8'd1) begin
              state_d = ST_CSUM;
            end
          end else begin
            if (uart_rx_data == sum_q) begin
              rd_d    = '0;
              state_d = ST_DRAIN;
            end else begin
              csum_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DRAIN: begin
        drop_d = uart_rx_done;
        if (hs) begin
          rd_d = rd_q + IW'(1);
          if (is_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      gap_q   <= '0;
      csum_q  <= 1'b0;
      lerr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      gap_q   <= gap_d;
      csum_q  <= csum_d;
      lerr_q  <= lerr_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid   = (state_q == ST_DRAIN);
  assign out_data    = out_valid ? rd_byte : 8'd0;
  assign out_last    = out_valid && is_last;
  assign frame_len   = len_q;
  assign err_csum    = csum_q;
  assign err_len     = lerr_q;
  assign err_timeout = tmo_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: a frame-level parser
// model predicts payload output and error pulses.
module tb_uart_rx_frame_parser;

  localparam int CLK_FRE = 2_000_000;
  localparam int BPS     = 200_000;
  localparam int MAX_LEN = 16;
  localparam int TO      = (CLK_FRE / BPS) * 20;
  localparam logic [7:0] HDR = 8'h55;
  localparam int K_CSUM = 0;
  localparam int K_LEN  = 1;
  localparam int K_TMO  = 2;
  localparam int K_DROP = 3;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [7:0] n;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] frame_len;
  logic       err_csum;
  logic       err_len;
  logic       err_timeout;
  logic       drop;

  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 0;
  exp_t q_out[$];
  int   q_evt[$];
  bq_t  seg;
  exp_t m_e;
  int   m_k;
  int   m_n;

  uart_rx_frame_parser #(
    .BPS     (BPS),
    .CLK_FRE (CLK_FRE),
    .MAX_LEN (MAX_LEN),
    .HDR     (HDR)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_rx_done (uart_rx_done),
    .uart_rx_data (uart_rx_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .frame_len    (frame_len),
    .err_csum     (err_csum),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
    .drop         (drop)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (out_valid && out_ready) begin
        if (q_out.size() == 0) begin
          chk("unexpected_out", out_data, 256);
        end else begin
          m_e = q_out.pop_front();
          chk("out_data", out_data, m_e.d);
          chk("out_last", out_last, m_e.l);
          chk("frame_len", frame_len, m_e.n);
        end
      end
      m_n = err_csum + err_len + err_timeout + drop;
      if (m_n > 1) chk("pulse_exclusive", m_n, 1);
      if (m_n != 0) begin
        m_k = err_csum ? K_CSUM : err_len ? K_LEN :
              err_timeout ? K_TMO : K_DROP;
        if (q_evt.size() == 0) chk("unexpected_evt", m_k, 9);
        else chk("evt_kind", m_k, q_evt.pop_front());
      end
    end
  end

  // Frame-level reference: scan the byte stream by frame rules
  task automatic model_seg(input bq_t s);
    int i;
    int n;
    int L;
    logic [7:0] sum;
    exp_t e;
    i = 0;
    n = s.size();
    while (i < n) begin
      if (s[i] != HDR) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin
        q_evt.push_back(K_TMO);
        break;
      end
      L = int'(s[i+1]);
      if (L == 0 || L > MAX_LEN) begin
        q_evt.push_back(K_LEN);
        i += 2;
        continue;
      end
      if (i + 2 + L >= n) begin
        q_evt.push_back(K_TMO);
        break;
      end
      sum = 8'(L);
      for (int j = 0; j < L; j++) sum = sum + s[i+2+j];
      if (s[i+2+L] == sum) begin
        for (int j = 0; j < L; j++) begin
          e.d = s[i+2+j];
          e.l = (j == L - 1);
          e.n = 8'(L);
          q_out.push_back(e);
        end
      end else begin
        q_evt.push_back(K_CSUM);
      end
      i += L + 3;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge sys_clk); #1;
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    @(posedge sys_clk); #1;
    uart_rx_done = 1'b0;
    repeat (gap) @(posedge sys_clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q_out.size() != 0 || q_evt.size() != 0) &&
           t < 3000) begin
      @(posedge sys_clk);
      t++;
    end
    chk("seg_complete", q_out.size() + q_evt.size(), 0);
    q_out.delete();
    q_evt.delete();
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  task automatic run_seg(input bq_t s, input int maxgap);
    model_seg(s);
    foreach (s[k]) send_byte(s[k], $urandom_range(0, maxgap));
    wait_idle();
  endtask

  function automatic logic [7:0] nonhdr();
    logic [7:0] b;
    do b = 8'($urandom); while (b == HDR);
    return b;
  endfunction

  task automatic add_frame(input bit bad);
    int L;
    logic [7:0] sum;
    logic [7:0] b;
    L = $urandom_range(1, MAX_LEN);
    seg.push_back(HDR);
    seg.push_back(8'(L));
    sum = 8'(L);
    for (int j = 0; j < L; j++) begin
      b = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom);
      seg.push_back(b);
      sum = sum + b;
    end
    if (bad) sum = sum ^ 8'($urandom_range(1, 255));
    seg.push_back(sum);
  endtask

  task automatic gen_seg();
    int r;
    int L;
    seg = {};
    repeat ($urandom_range(0, 3)) begin
      case ($urandom_range(0, 2))
        0: repeat ($urandom_range(1, 3)) seg.push_back(nonhdr());
        1: begin
          seg.push_back(HDR);
          if ($urandom_range(0, 1) == 1) seg.push_back(8'd0);
          else seg.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        end
        default: add_frame(1'b1);
      endcase
    end
    r = $urandom_range(0, 9);
    if (r < 7) begin
      add_frame(1'b0);
    end else if (r < 9) begin
      seg.push_back(HDR);
      if ($urandom_range(0, 1) == 1) begin
        L = $urandom_range(1, MAX_LEN);
        seg.push_back(8'(L));
        repeat ($urandom_range(0, L)) seg.push_back(8'($urandom));
      end
    end
  endtask

  initial begin
    sys_rst      = 1'b1;
    uart_rx_done = 1'b0;
    uart_rx_data = 8'd0;
    out_ready    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_errs", err_csum | err_len | err_timeout | drop, 0);

    ready_mode = 2;
    run_seg('{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 3);
    ready_mode = 0;
    run_seg('{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00}, 3);
    run_seg('{8'h55, 8'h02, 8'h0A, 8'h0B, 8'h17}, 3);
    run_seg('{8'h55, 8'h00}, 3);
    run_seg('{8'h55, 8'h11}, 3);
    run_seg('{8'h55, 8'h02, 8'hAA}, 3);
    run_seg('{8'h55, 8'h01, 8'h7F, 8'h80}, 3);
    run_seg('{8'h12, 8'h55, 8'h55, 8'h01, 8'h55, 8'h56}, 3);
    run_seg('{8'h55, 8'h01, 8'h55, 8'h56}, 3);
    run_seg('{8'h55, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
              8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
              8'h98}, 0);

    // Sink stalled while three more bytes arrive
    ready_mode = 1;
    repeat (2) @(posedge sys_clk);
    seg = '{8'h55, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h19};
    model_seg(seg);
    foreach (seg[k]) send_byte(seg[k], 1);
    for (int d = 0; d < 3; d++) begin
      q_evt.push_back(K_DROP);
      send_byte(8'($urandom), 2);
    end
    for (int c = 0; c < 50; c++) begin
      @(posedge sys_clk); #1;
      if (c % 16 == 0) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, 8'hA1);
        chk("hold_last", out_last, 0);
        chk("hold_len", frame_len, 3);
      end
    end
    ready_mode = 0;
    wait_idle();

    // Reset in the middle of a payload
    send_byte(8'h55, 1);
    send_byte(8'h04, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    sys_rst = 1'b1;
    #3;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_len", frame_len, 0);
    chk("midrst_errs", err_csum | err_len | err_timeout | drop, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (TO + 20) @(posedge sys_clk);
    #1;
    chk("post_rst_valid", out_valid, 0);
    run_seg('{8'h55, 8'h02, 8'h33, 8'h44, 8'h79}, 3);

    for (int s = 0; s < 40; s++) begin
      gen_seg();
      run_seg(seg, 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
